// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush/forward control for a 5-stage pipeline with memory-wait freeze.
// Define HAZARD_FORWARDING_EN to enable X/M and M/W operand forwarding.
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int RA_W        = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [RA_W-1:0] id_rs_addr,
    input  logic [RA_W-1:0] id_rt_addr,
    input  logic [RA_W-1:0] dx_rs_addr,
    input  logic [RA_W-1:0] dx_rt_addr,
    input  logic [RA_W-1:0] dx_write_reg_addr,
    input  logic            dx_reg_write,
    input  logic            dx_mem_read,
    input  logic [RA_W-1:0] xm_write_reg_addr,
    input  logic            xm_reg_write,
    input  logic            xm_mem_read,
    input  logic            xm_mem_write,
    input  logic [RA_W-1:0] mw_write_reg_addr,
    input  logic            mw_reg_write,
    input  logic            branch_taken,
    input  logic            mem_ready,
    output logic            pc_en,
    output logic            fd_en,
    output logic            xm_en,
    output logic            fd_flush,
    output logic            dx_flush,
    output logic            xm_flush,
    output logic [1:0]      fwd_a_sel,
    output logic [1:0]      fwd_b_sel,
    output logic            mem_timeout
);
    typedef enum logic {RUN, MEM_WAIT} state_t;
    state_t state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic tmo_q, tmo_d;
    logic wait_st, freeze, fire, load_use, raw;
    logic [1:0] fwd_a, fwd_b;
    function automatic logic hit(input logic we, input logic [RA_W-1:0] wa, input logic [RA_W-1:0] ra);
        return we && (wa == ra) && (wa != '0);
    endfunction
    always_comb begin
        wait_st  = state_q == MEM_WAIT;
        freeze   = (wait_st | xm_mem_read | xm_mem_write) & ~mem_ready;
        fire     = wait_st & ~mem_ready & (cnt_q == 8'(MEM_TIMEOUT - 1));
        load_use = dx_mem_read & (hit(dx_reg_write, dx_write_reg_addr, id_rs_addr)
                                | hit(dx_reg_write, dx_write_reg_addr, id_rt_addr));
`ifdef HAZARD_FORWARDING_EN
        raw   = load_use;
        fwd_a = hit(xm_reg_write, xm_write_reg_addr, dx_rs_addr) ? 2'b01 :
                hit(mw_reg_write, mw_write_reg_addr, dx_rs_addr) ? 2'b10 : 2'b00;
        fwd_b = hit(xm_reg_write, xm_write_reg_addr, dx_rt_addr) ? 2'b01 :
                hit(mw_reg_write, mw_write_reg_addr, dx_rt_addr) ? 2'b10 : 2'b00;
`else
        // Without forwarding, any in-flight writer in X or X/M blocks decode; M/W is covered by regfile bypass.
        raw   = load_use
              | hit(dx_reg_write, dx_write_reg_addr, id_rs_addr) | hit(dx_reg_write, dx_write_reg_addr, id_rt_addr)
              | hit(xm_reg_write, xm_write_reg_addr, id_rs_addr) | hit(xm_reg_write, xm_write_reg_addr, id_rt_addr);
        fwd_a = 2'b00;
        fwd_b = 2'b00;
`endif
        pc_en       = ~rst & ~freeze & (branch_taken | ~raw);
        fd_en       = ~rst & ~freeze & (branch_taken | ~raw);
        xm_en       = ~rst & ~freeze;
        fd_flush    = rst | (~freeze & branch_taken);
        dx_flush    = rst | (~freeze & (branch_taken | raw));
        xm_flush    = rst | fire;
        fwd_a_sel   = rst ? 2'b00 : fwd_a;
        fwd_b_sel   = rst ? 2'b00 : fwd_b;
        mem_timeout = tmo_q | (~rst & fire);
        state_d     = (freeze & ~fire) ? MEM_WAIT : RUN;
        cnt_d       = ~wait_st ? 8'd0 : (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        tmo_d       = tmo_q | fire;
    end
`ifndef HAZARD_FORWARDING_EN
    logic unused_fwd;
    assign unused_fwd = ^{dx_rs_addr, dx_rt_addr, mw_write_reg_addr, mw_reg_write};
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= 8'd0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
        end
    end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed vectors with a per-cycle behavioural model and literal checkpoints.
module tb_pipeline_hazard_ctrl;
    localparam int RA_W = 5;
    localparam int MEM_TIMEOUT = 15;
    logic clk = 0, rst = 1;
    logic [RA_W-1:0] id_rs_addr, id_rt_addr, dx_rs_addr, dx_rt_addr;
    logic [RA_W-1:0] dx_write_reg_addr, xm_write_reg_addr, mw_write_reg_addr;
    logic dx_reg_write, dx_mem_read, xm_reg_write, xm_mem_read, xm_mem_write, mw_reg_write;
    logic branch_taken, mem_ready;
    logic pc_en, fd_en, xm_en, fd_flush, dx_flush, xm_flush, mem_timeout;
    logic [1:0] fwd_a_sel, fwd_b_sel;
    int checks = 0, failures = 0;
    bit m_wait = 0, m_flag = 0;
    int m_n = 0;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .RA_W(RA_W)) dut (
        .clk(clk), .rst(rst),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .dx_rs_addr(dx_rs_addr), .dx_rt_addr(dx_rt_addr),
        .dx_write_reg_addr(dx_write_reg_addr), .dx_reg_write(dx_reg_write), .dx_mem_read(dx_mem_read),
        .xm_write_reg_addr(xm_write_reg_addr), .xm_reg_write(xm_reg_write),
        .xm_mem_read(xm_mem_read), .xm_mem_write(xm_mem_write),
        .mw_write_reg_addr(mw_write_reg_addr), .mw_reg_write(mw_reg_write),
        .branch_taken(branch_taken), .mem_ready(mem_ready),
        .pc_en(pc_en), .fd_en(fd_en), .xm_en(xm_en),
        .fd_flush(fd_flush), .dx_flush(dx_flush), .xm_flush(xm_flush),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .mem_timeout(mem_timeout)
    );

    always #5 clk = ~clk;

    function automatic bit wm(input logic we, input logic [RA_W-1:0] wa, input logic [RA_W-1:0] ra);
        return we && wa == ra && wa != 0;
    endfunction

    // Expected outputs {pc,fd,xm,fd_fl,dx_fl,xm_fl,fwd_a,fwd_b,timeout} from the hazard rules.
    function automatic logic [10:0] m_eval(output bit fire, output bit frozen);
        bit stall;
        logic [5:0] ctl;
        logic [1:0] fa, fb;
        fire = 0; frozen = 0; fa = 0; fb = 0;
        if (rst) return {6'b000111, 4'b0000, m_flag};
        frozen = m_wait ? !mem_ready : ((xm_mem_read || xm_mem_write) && !mem_ready);
        fire = frozen && m_wait && m_n == MEM_TIMEOUT - 1;
        stall = dx_mem_read && (wm(dx_reg_write, dx_write_reg_addr, id_rs_addr) || wm(dx_reg_write, dx_write_reg_addr, id_rt_addr));
`ifdef HAZARD_FORWARDING_EN
        fa = wm(xm_reg_write, xm_write_reg_addr, dx_rs_addr) ? 2'd1 : wm(mw_reg_write, mw_write_reg_addr, dx_rs_addr) ? 2'd2 : 2'd0;
        fb = wm(xm_reg_write, xm_write_reg_addr, dx_rt_addr) ? 2'd1 : wm(mw_reg_write, mw_write_reg_addr, dx_rt_addr) ? 2'd2 : 2'd0;
`else
        stall = stall || wm(dx_reg_write, dx_write_reg_addr, id_rs_addr) || wm(dx_reg_write, dx_write_reg_addr, id_rt_addr)
                      || wm(xm_reg_write, xm_write_reg_addr, id_rs_addr) || wm(xm_reg_write, xm_write_reg_addr, id_rt_addr);
`endif
        if (frozen) ctl = {5'b00000, fire};
        else if (branch_taken) ctl = 6'b111110;
        else if (stall) ctl = 6'b001010;
        else ctl = 6'b111000;
        return {ctl, fa, fb, m_flag || fire};
    endfunction

    always @(posedge clk) begin
        bit fire, frozen;
        logic [10:0] unused_e;
        unused_e = m_eval(fire, frozen);
        if (rst) begin m_wait <= 0; m_n <= 0; m_flag <= 0; end
        else if (fire) begin m_wait <= 0; m_n <= 0; m_flag <= 1; end
        else if (frozen) begin m_wait <= 1; m_n <= m_wait ? m_n + 1 : 0; end
        else begin m_wait <= 0; m_n <= 0; end
    end

    always @(negedge clk) begin
        bit fire, frozen;
        logic [10:0] e, g;
        e = m_eval(fire, frozen);
        g = {pc_en, fd_en, xm_en, fd_flush, dx_flush, xm_flush, fwd_a_sel, fwd_b_sel, mem_timeout};
        checks++;
        if (g !== e) begin
            failures++;
            $display("FAIL model t=%0t got=%b exp=%b", $time, g, e);
        end
    end

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        {id_rs_addr, id_rt_addr, dx_rs_addr, dx_rt_addr} = '0;
        {dx_write_reg_addr, xm_write_reg_addr, mw_write_reg_addr} = '0;
        {dx_reg_write, dx_mem_read, xm_reg_write, xm_mem_read, xm_mem_write, mw_reg_write} = '0;
        branch_taken = 0;
        mem_ready = 0;
    endtask

    initial begin
        int n;
        quiet();
        step(); step();
        #3;
        chk("rst_pc_en", pc_en, 0);
        chk("rst_flushes", {fd_flush, dx_flush, xm_flush}, 7);
        chk("rst_fwd", {fwd_a_sel, fwd_b_sel}, 0);
        step(); rst = 0; #3;
        chk("idle_en", {pc_en, fd_en, xm_en}, 7);
        chk("idle_flush", {fd_flush, dx_flush, xm_flush}, 0);
        // load-use on rs=3: single bubble
        step(); dx_mem_read = 1; dx_reg_write = 1; dx_write_reg_addr = 3; id_rs_addr = 3; #3;
        chk("lu_stall", {pc_en, fd_en, dx_flush, xm_en}, 4'b0011);
        step(); quiet(); #3;
        chk("lu_one_cycle", pc_en, 1);
        step(); dx_mem_read = 1; dx_reg_write = 1; dx_write_reg_addr = 0; id_rs_addr = 0; #3;
        chk("lu_addr0", {pc_en, dx_flush}, 2'b10);
        // branch beats load-use
        step(); dx_write_reg_addr = 3; id_rs_addr = 3; branch_taken = 1; #3;
        chk("br_over_lu", {pc_en, fd_en, xm_en, fd_flush, dx_flush}, 5'b11111);
        // 4-cycle memory wait then release
        step(); quiet(); xm_mem_read = 1;
        for (int i = 0; i < 4; i++) begin
            #3;
            chk("mw_freeze", {pc_en, fd_en, xm_en}, 0);
            step();
        end
        mem_ready = 1; #3;
        chk("mw_release", {pc_en, fd_en, xm_en}, 7);
        chk("mw_no_timeout", mem_timeout, 0);
        // branch held during freeze acts in release cycle
        step(); quiet(); xm_mem_write = 1; branch_taken = 1; #3;
        chk("br_frz_hold", {pc_en, fd_flush, dx_flush}, 0);
        step(); #3;
        chk("br_frz_hold2", {pc_en, fd_flush}, 0);
        step(); mem_ready = 1; #3;
        chk("br_release", {pc_en, fd_flush, dx_flush}, 7);
        // decode RAW against X/M writer, and forwarding selection
        step(); quiet(); xm_reg_write = 1; xm_write_reg_addr = 7; id_rt_addr = 7; #3;
`ifdef HAZARD_FORWARDING_EN
        chk("raw_xm", {pc_en, dx_flush}, 2'b10);
`else
        chk("raw_xm", {pc_en, dx_flush}, 2'b01);
`endif
        step(); id_rt_addr = 0; mw_reg_write = 1; mw_write_reg_addr = 7; dx_rs_addr = 7; #3;
`ifdef HAZARD_FORWARDING_EN
        chk("fwd_xm", fwd_a_sel, 1);
`else
        chk("fwd_xm", fwd_a_sel, 0);
`endif
        chk("fwd_b_none", fwd_b_sel, 0);
        step(); xm_reg_write = 0; #3;
`ifdef HAZARD_FORWARDING_EN
        chk("fwd_mw", fwd_a_sel, 2);
`else
        chk("fwd_mw", fwd_a_sel, 0);
`endif
        // timeout: 1 RUN freeze cycle, then abandon on the 15th MEM_WAIT cycle
        step(); quiet(); xm_mem_read = 1;
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            #3;
            if (xm_flush) begin n = i; break; end
            step();
        end
        chk("to_cycle", n, MEM_TIMEOUT + 1);
        chk("to_flag", mem_timeout, 1);
        chk("to_freeze", {pc_en, xm_en}, 0);
        step(); quiet(); #3;
        chk("to_back_run", pc_en, 1);
        step(); step(); #3;
        chk("to_sticky", mem_timeout, 1);
        // reset in the middle of MEM_WAIT
        step(); xm_mem_read = 1;
        step(); step(); rst = 1; #3;
        chk("rst_mid_en", {pc_en, fd_en, xm_en}, 0);
        step(); rst = 0; quiet(); #3;
        chk("rst_mid_run", {pc_en, fd_en, xm_en}, 7);
        chk("rst_mid_flag", mem_timeout, 0);
        step(); step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15: max MEM_WAIT cycles before abandon (1..255).
REQ-002 SHALL have parameter RA_W, default 5: register address width.
REQ-003 SHALL have ports:
  clk  in  1  clock, all state changes on rising edge
  rst  in  1  reset, synchronous, active-high
  id_rs_addr, id_rt_addr  in  RA_W  sources of instruction in decode
  dx_rs_addr, dx_rt_addr  in  RA_W  sources of instruction in execute
  dx_write_reg_addr  in  RA_W;  dx_reg_write, dx_mem_read  in  1
  xm_write_reg_addr  in  RA_W;  xm_reg_write, xm_mem_read, xm_mem_write  in  1
  mw_write_reg_addr  in  RA_W;  mw_reg_write  in  1
  branch_taken  in  1  branch resolved taken in memory stage
  mem_ready  in  1  data memory completes access this cycle
  pc_en, fd_en, xm_en  out  1  load enables for PC, F/D, X/M registers
  fd_flush, dx_flush, xm_flush  out  1  bubble-insert controls
  fwd_a_sel, fwd_b_sel  out  2  operand source: 00 regfile, 01 X/M, 10 M/W
  mem_timeout  out  1  sticky memory-timeout flag

Function
REQ-004 SHALL implement FSM states RUN, MEM_WAIT; enable and flush outputs combinational from state and inputs.
REQ-005 A register match SHALL require writer reg_write=1, addresses equal and address nonzero.
REQ-006 RUN, xm_mem_read|xm_mem_write=1, mem_ready=0: pc_en=fd_en=xm_en=0, all flushes 0; next state MEM_WAIT, wait counter cleared to 0.
REQ-007 MEM_WAIT: same freeze outputs; counter +1 per cycle; mem_ready=1 -> freeze released that cycle (outputs as RUN), next RUN.
REQ-008 MEM_WAIT, counter = MEM_TIMEOUT-1, mem_ready=0: xm_flush=1, xm_en=0, mem_timeout set, next RUN; mem_timeout cleared only by rst.
REQ-009 RUN, no freeze, branch_taken=1: pc_en=fd_en=xm_en=1, fd_flush=dx_flush=1 for that cycle.
REQ-010 RUN, no freeze, no branch, load-use (dx_mem_read=1, dx writer matches id_rs or id_rt): pc_en=fd_en=0, dx_flush=1, xm_en=1; one bubble.
REQ-011 Priority SHALL be freeze > branch flush > data stall; branch_taken during freeze is held by frozen X/M and acted on in the release cycle.
REQ-012 Otherwise pc_en=fd_en=xm_en=1, all flushes 0.
REQ-013 Counter SHALL be 8 bits, saturating, never wraps.

Reset
REQ-014 rst=1 at clock edge: state RUN, counter 0, mem_timeout 0, including mid-MEM_WAIT.
REQ-015 While rst=1: pc_en=fd_en=xm_en=0, fd_flush=dx_flush=xm_flush=1, fwd_a_sel=fwd_b_sel=00.

Configuration
REQ-016 Macro HAZARD_FORWARDING_EN defined: fwd_a_sel/fwd_b_sel = 01 if xm writer matches dx_rs/dx_rt, else 10 if mw writer matches, else 00; X/M has priority; data stall only per REQ-010.
REQ-017 Macro undefined: fwd_a_sel=fwd_b_sel=00 always; data stall per REQ-010 also when any dx or xm writer matches id_rs or id_rt (regfile write-before-read covers M/W).

Verification
REQ-018 rst 1 cycle during MEM_WAIT -> next cycle state RUN, mem_timeout=0, enables=1 once inputs quiet.
REQ-019 dx_mem_read=1, dx_write_reg_addr=3, id_rs_addr=3 -> exactly one cycle pc_en=0, fd_en=0, dx_flush=1; same with addr 0 -> no stall.
REQ-020 xm_mem_read=1, mem_ready low 4 cycles then high -> pc_en=fd_en=xm_en=0 for 4 cycles, 1 on 5th; mem_timeout=0.
REQ-021 MEM_TIMEOUT=15, mem_ready held 0 -> xm_flush=1 and mem_timeout=1 on cycle 15, state RUN next; flag stays 1 until rst.
REQ-022 branch_taken=1 with load-use condition -> fd_flush=dx_flush=1, pc_en=1, no stall; branch_taken during freeze -> flush in release cycle.
REQ-023 With HAZARD_FORWARDING_EN: xm and mw writers both addr 7, dx_rs_addr=7 -> fwd_a_sel=01; xm_reg_write=0 -> 10; undefined: both 00 and decode RAW stalls.
